// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 command decoder.
//   PS2_BREAK / PS2_EXT : prefix bytes of the PS/2 set-2 protocol
//   estado_t            : session FSM state
//   TECLA_*             : default make codes used by the equalizer
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [0:0] {
    ESPERA = 1'b0,
    ACTIVO = 1'b1
  } estado_t;

  localparam logic [7:0] TECLA_T     = 8'h2C;
  localparam logic [7:0] TECLA_A     = 8'h1C;
  localparam logic [7:0] TECLA_B     = 8'h32;
  localparam logic [7:0] TECLA_M     = 8'h3A;
  localparam logic [7:0] TECLA_Q     = 8'h15;
  localparam logic [7:0] TECLA_ENTER = 8'h5A;

endpackage

// File: rtl/ps2_prefijo.sv
// ps2_prefijo: tracks the F0 (break) and E0 (extended) prefixes.
//   clk, reset          : clock, synchronous active-high reset
//   rx_dato, rx_listo   : received byte and its one-cycle strobe
//   rx_error            : receiver error strobe, discards pending prefixes
//   code_listo          : strobe, a non-prefix byte completed a code (same cycle)
//   code_dato           : the completing byte
//   code_brk, code_ext  : prefixes seen before the completing byte
module ps2_prefijo
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_dato,
  input  logic       rx_listo,
  input  logic       rx_error,
  output logic       code_listo,
  output logic [7:0] code_dato,
  output logic       code_brk,
  output logic       code_ext
);

  logic brk;
  logic ext;
  logic es_prefijo;

  assign es_prefijo = (rx_dato == PS2_BREAK) || (rx_dato == PS2_EXT);

  // Combinational strobe so the decoder can register its pulse in the
  // very cycle after rx_listo.
  assign code_listo = rx_listo && !rx_error && !es_prefijo;
  assign code_dato  = rx_dato;
  assign code_brk   = brk;
  assign code_ext   = ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_error || code_listo) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_listo) begin
      if (rx_dato == PS2_BREAK) brk <= 1'b1;
      if (rx_dato == PS2_EXT)   ext <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_comando_decoder.sv
// ps2_comando_decoder: session FSM, key table search and typematic filter.
//   clk, reset : clock, synchronous active-high reset
//   rx_dato    : byte from the PS/2 receiver, valid with rx_listo
//   rx_listo   : byte strobe
//   rx_error   : receiver parity/frame error strobe
//   valida     : pulse, table key accepted in a session
//   tecla_idx  : index of the last accepted key (held)
//   iniciar    : pulse, session start/restart
//   terminar   : pulse, session end
//   activo     : level, session active
//   error      : pulse, unknown code in a session or receiver error
//
// state  | meaning
// ESPERA | idle, only COD_INICIAR is acted on
// ACTIVO | session open, keys decoded
module ps2_comando_decoder
  import ps2_pkg::*;
#(
  parameter int                      N_TECLAS     = 4,
  parameter logic [N_TECLAS*8-1:0]   TECLAS       = {8'h3A, 8'h32, 8'h1C, 8'h2C},
  parameter logic [7:0]              COD_INICIAR  = 8'h15,
  parameter logic [7:0]              COD_TERMINAR = 8'h5A,
  parameter int                      FILTRAR_REP  = 1,
  parameter int                      IDX_W        = (N_TECLAS > 1) ? $clog2(N_TECLAS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_dato,
  input  logic             rx_listo,
  input  logic             rx_error,
  output logic             valida,
  output logic [IDX_W-1:0] tecla_idx,
  output logic             iniciar,
  output logic             terminar,
  output logic             activo,
  output logic             error
);

  logic       code_listo;
  logic [7:0] code_dato;
  logic       code_brk;
  logic       code_ext;

  estado_t    estado;
  logic [7:0] ultima;
  logic       held;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             repetido;

  ps2_prefijo u_prefijo (
    .clk        (clk),
    .reset      (reset),
    .rx_dato    (rx_dato),
    .rx_listo   (rx_listo),
    .rx_error   (rx_error),
    .code_listo (code_listo),
    .code_dato  (code_dato),
    .code_brk   (code_brk),
    .code_ext   (code_ext)
  );

  // Lowest matching table index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_TECLAS; i++) begin
      if (!hit && (TECLAS[8*i +: 8] == code_dato)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign repetido = (FILTRAR_REP != 0) && held && (code_dato == ultima);
  assign activo   = (estado == ACTIVO);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= ESPERA;
      ultima    <= 8'h00;
      held      <= 1'b0;
      valida    <= 1'b0;
      iniciar   <= 1'b0;
      terminar  <= 1'b0;
      error     <= 1'b0;
      tecla_idx <= '0;
    end else begin
      valida   <= 1'b0;
      iniciar  <= 1'b0;
      terminar <= 1'b0;
      error    <= 1'b0;
      if (rx_error) begin
        error <= 1'b1;
      end else if (code_listo && code_brk) begin
        if (code_dato == ultima) held <= 1'b0;
      end else if (code_listo && !repetido) begin
        ultima <= code_dato;
        held   <= 1'b1;
        if (code_ext) begin
          // Extended makes matter only inside a session; E0 5A is keypad Enter.
          if (estado == ACTIVO) begin
            if (code_dato == TECLA_ENTER) begin
              terminar <= 1'b1;
              estado   <= ESPERA;
            end else begin
              error <= 1'b1;
            end
          end
        end else if (estado == ESPERA) begin
          if (code_dato == COD_INICIAR) begin
            iniciar <= 1'b1;
            estado  <= ACTIVO;
          end
        end else begin
          if (hit) begin
            valida    <= 1'b1;
            tecla_idx <= hit_idx;
          end else if (code_dato == COD_TERMINAR) begin
            terminar <= 1'b1;
            estado   <= ESPERA;
          end else if (code_dato == COD_INICIAR) begin
            iniciar <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
      end
    end
  end

endmodule
